// File: rtl/knn_pkg.sv
// knn_pkg: shared widths, types and helpers for the KNN distance/insert datapath.
//   DATA_W   : distance and list entry width
//   K        : number of neighbour slots in the sorted list
//   COORD_W  : coordinate width (half of DATA_W)
//   coord_t  : one unsigned coordinate
//   dist_t   : one unsigned (squared) distance / list entry
//   DIST_MAX : all-ones distance, used as the empty-slot marker
package knn_pkg;

    localparam int DATA_W  = 32;
    localparam int K       = 4;
    localparam int COORD_W = DATA_W / 2;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [DATA_W-1:0]  dist_t;

    localparam dist_t DIST_MAX = {DATA_W{1'b1}};

    // Unsigned absolute difference; never wraps because the larger operand
    // is always the minuend.
    function automatic coord_t abs_diff(input coord_t a, input coord_t b);
        coord_t d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = b - a;
        end
        return d;
    endfunction

endpackage

// File: rtl/knn_core.sv
// knn_core: combinational squared-Euclidean distance between two 2-D points.
// Ports:
//   clk, rst        : present for uniform integration; no state is kept
//   KNN_ENABLE      : when low, z is forced to zero
//   x1, x2, y1, y2  : unsigned coordinates of the two points
//   z               : dx^2 + dy^2, saturated to DIST_MAX on overflow
module knn_core
    import knn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              KNN_ENABLE,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] x2,
    input  logic [COORD_W-1:0] y1,
    input  logic [COORD_W-1:0] y2,
    output logic [DATA_W-1:0] z
);

    coord_t            dx_s;
    coord_t            dy_s;
    dist_t             dx_sq_s;
    dist_t             dy_sq_s;
    logic [DATA_W:0]   sum_s;

    // Clock and reset have no function here; fold them into a sink.
    wire unused_s = &{1'b0, clk, rst};

    // Distance datapath: two squares, one extra carry bit for the add.
    always_comb begin
        dx_s    = abs_diff(x1, x2);
        dy_s    = abs_diff(y1, y2);
        dx_sq_s = dist_t'(dx_s) * dist_t'(dx_s);
        dy_sq_s = dist_t'(dy_s) * dist_t'(dy_s);
        sum_s   = {1'b0, dx_sq_s} + {1'b0, dy_sq_s};
    end

    // Output select: disable wins, then saturation on carry-out.
    always_comb begin
        if (!KNN_ENABLE) begin
            z = {DATA_W{1'b0}};
        end else if (sum_s[DATA_W]) begin
            z = DIST_MAX;
        end else begin
            z = sum_s[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/knn_list.sv
// knn_list: combinational insertion of one distance into an ascending K-slot
// list; the previous largest entry falls off the end.
// Ports:
//   clk, rst        : unused, present for uniform integration
//   neighbour_data  : current list, slot i at [(i+1)*DATA_W-1 : i*DATA_W], slot 0 nearest
//   dist_target     : candidate distance
//   list_out        : updated list, same packing
module knn_list
    import knn_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [K*DATA_W-1:0] neighbour_data,
    input  logic [DATA_W-1:0]   dist_target,
    output logic [K*DATA_W-1:0] list_out
);

    wire unused_s = &{1'b0, clk, rst};

    // Each slot decides independently: keep its entry, take the target, or
    // take the entry shifted down from the slot above. Using >= keeps ties
    // stable (target lands after equal entries).
    for (genvar i = 0; i < K; i++) begin : g_slot
        dist_t cur_s;
        dist_t out_s;

        assign cur_s = neighbour_data[i*DATA_W +: DATA_W];

        if (i == 0) begin : g_first
            // Slot 0 has no predecessor: keep or take target.
            always_comb begin
                if (dist_target >= cur_s) begin
                    out_s = cur_s;
                end else begin
                    out_s = dist_target;
                end
            end
        end else begin : g_rest
            dist_t prev_s;

            assign prev_s = neighbour_data[(i-1)*DATA_W +: DATA_W];

            // Keep, insert here, or shift the predecessor down.
            always_comb begin
                if (dist_target >= cur_s) begin
                    out_s = cur_s;
                end else if (dist_target >= prev_s) begin
                    out_s = dist_target;
                end else begin
                    out_s = prev_s;
                end
            end
        end

        assign list_out[i*DATA_W +: DATA_W] = out_s;
    end

endmodule

// File: rtl/knn_dist_insert.sv
// knn_dist_insert: KNN datapath wrapper holding the distance unit and the
// sorted-list insertion unit side by side. Both are purely combinational;
// the enclosing controller owns sequencing and list storage.
// Ports:
//   clk, rst        : shared clock / synchronous active-high reset (no effect on outputs)
//   KNN_ENABLE      : distance output enable
//   x1, x2, y1, y2  : point coordinates
//   z               : squared distance (saturated)
//   neighbour_data  : current ascending list
//   dist_target     : candidate distance to insert
//   list_out        : updated list
module knn_dist_insert
    import knn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 KNN_ENABLE,
    input  logic [COORD_W-1:0]   x1,
    input  logic [COORD_W-1:0]   x2,
    input  logic [COORD_W-1:0]   y1,
    input  logic [COORD_W-1:0]   y2,
    output logic [DATA_W-1:0]    z,
    input  logic [K*DATA_W-1:0]  neighbour_data,
    input  logic [DATA_W-1:0]    dist_target,
    output logic [K*DATA_W-1:0]  list_out
);

    knn_core u_core (
        .clk        (clk),
        .rst        (rst),
        .KNN_ENABLE (KNN_ENABLE),
        .x1         (x1),
        .x2         (x2),
        .y1         (y1),
        .y2         (y2),
        .z          (z)
    );

    knn_list u_list (
        .clk            (clk),
        .rst            (rst),
        .neighbour_data (neighbour_data),
        .dist_target    (dist_target),
        .list_out       (list_out)
    );

endmodule

// File: tb/tb_knn_dist_insert.sv
// Self-checking bench for knn_dist_insert: directed vectors, a behavioural
// model compared every cycle, and hand-computed literal expectations.
module tb_knn_dist_insert;
    import knn_pkg::*;

    localparam logic [31:0] MX = 32'hFFFF_FFFF;

    logic                clk;
    logic                rst;
    logic                KNN_ENABLE;
    logic [COORD_W-1:0]  x1, x2, y1, y2;
    logic [DATA_W-1:0]   z;
    logic [K*DATA_W-1:0] neighbour_data;
    logic [DATA_W-1:0]   dist_target;
    logic [K*DATA_W-1:0] list_out;

    int n_vec = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    knn_dist_insert dut (
        .clk            (clk),
        .rst            (rst),
        .KNN_ENABLE     (KNN_ENABLE),
        .x1             (x1),
        .x2             (x2),
        .y1             (y1),
        .y2             (y2),
        .z              (z),
        .neighbour_data (neighbour_data),
        .dist_target    (dist_target),
        .list_out       (list_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [K*DATA_W-1:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                                  input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    // Model: squared Euclidean distance in wide signed arithmetic, clipped.
    function automatic logic [31:0] model_dist(input bit en, input logic [15:0] a1, input logic [15:0] a2,
                                               input logic [15:0] b1, input logic [15:0] b2);
        longint dx, dy, s;
        if (!en) return 32'd0;
        dx = longint'(a1) - longint'(a2);
        dy = longint'(b1) - longint'(b2);
        s  = dx * dx + dy * dy;
        if (s > 64'sd4294967295) return MX;
        return s[31:0];
    endfunction

    // Model: walk the sorted list, drop the target in before the first entry
    // strictly greater than it, then keep only the first K elements.
    function automatic logic [K*DATA_W-1:0] model_insert(input logic [K*DATA_W-1:0] lst,
                                                         input logic [31:0] t);
        logic [31:0] q[$];
        logic [K*DATA_W-1:0] r;
        bit placed;
        placed = 1'b0;
        for (int i = 0; i < K; i++) begin
            if (!placed && t < lst[i*32 +: 32]) begin
                q.push_back(t);
                placed = 1'b1;
            end
            q.push_back(lst[i*32 +: 32]);
        end
        if (!placed) q.push_back(t);
        r = '0;
        for (int i = 0; i < K; i++) r[i*32 +: 32] = q[i];
        return r;
    endfunction

    task automatic chk_z(input string name, input logic [31:0] exp);
        n_vec++;
        if (z !== exp) begin
            n_err++;
            $display("FAIL %s: z got %0d (0x%08h) expected %0d (0x%08h)", name, z, z, exp, exp);
        end
    endtask

    task automatic chk_list(input string name, input logic [K*DATA_W-1:0] exp);
        n_vec++;
        if (list_out !== exp) begin
            n_err++;
            $display("FAIL %s: list got %h expected %h", name, list_out, exp);
        end
    endtask

    // Compare process: model vs DUT on every falling edge once stimulus is live.
    always @(negedge clk) begin
        if (check_en) begin
            chk_z("model_z", model_dist(KNN_ENABLE, x1, x2, y1, y2));
            chk_list("model_list", model_insert(neighbour_data, dist_target));
        end
    end

    task automatic drive(input bit en, input int a1, input int a2, input int b1, input int b2,
                         input logic [K*DATA_W-1:0] lst, input logic [31:0] t);
        @(posedge clk);
        #1;
        KNN_ENABLE     = en;
        x1             = 16'(a1);
        x2             = 16'(a2);
        y1             = 16'(b1);
        y2             = 16'(b2);
        neighbour_data = lst;
        dist_target    = t;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        KNN_ENABLE     = 1'b0;
        x1 = 16'd0; x2 = 16'd0; y1 = 16'd0; y2 = 16'd0;
        neighbour_data = pack4(MX, MX, MX, MX);
        dist_target    = MX;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk_z("reset_z", 32'd0);
        chk_list("reset_list", pack4(MX, MX, MX, MX));
        check_en = 1'b1;
        rst = 1'b0;

        // Distance cases
        drive(1'b1, 1, 4, 8, 3, pack4(MX, MX, MX, MX), MX);
        chk_z("dist_basic_34", 32'd34);
        drive(1'b1, 3, 15, 20, 50, pack4(MX, MX, MX, MX), MX);
        chk_z("dist_basic_1044", 32'd1044);
        drive(1'b1, 132, 33, 640, 12, pack4(MX, MX, MX, MX), MX);
        chk_z("dist_wide", 32'd404185);
        drive(1'b1, 16'hFFFF, 0, 16'hFFFF, 0, pack4(MX, MX, MX, MX), MX);
        chk_z("dist_sat", MX);
        drive(1'b1, 16'hFFFF, 0, 0, 0, pack4(MX, MX, MX, MX), MX);
        chk_z("dist_no_sat", 32'hFFFE_0001);
        drive(1'b0, 16'hFFFF, 0, 16'hFFFF, 0, pack4(MX, MX, MX, MX), MX);
        chk_z("dist_disabled", 32'd0);
        drive(1'b1, 7, 7, 9, 9, pack4(MX, MX, MX, MX), MX);
        chk_z("dist_zero", 32'd0);

        // Insertion cases
        drive(1'b1, 1, 4, 8, 3, pack4(1, 2, 4, 8), 3);
        chk_list("ins_mid", pack4(1, 2, 3, 4));
        drive(1'b1, 1, 4, 8, 3, pack4(1, 2, 4, 8), 0);
        chk_list("ins_front", pack4(0, 1, 2, 4));
        drive(1'b1, 1, 4, 8, 3, pack4(1, 2, 4, 8), 8);
        chk_list("ins_eq_last", pack4(1, 2, 4, 8));
        drive(1'b1, 1, 4, 8, 3, pack4(1, 2, 4, 8), 9);
        chk_list("ins_beyond", pack4(1, 2, 4, 8));
        drive(1'b1, 1, 4, 8, 3, pack4(1, 2, 4, 8), 7);
        chk_list("ins_last", pack4(1, 2, 4, 7));
        drive(1'b1, 1, 4, 8, 3, pack4(1, 2, 4, 8), 2);
        chk_list("ins_tie_mid", pack4(1, 2, 2, 4));
        drive(1'b1, 1, 4, 8, 3, pack4(5, 5, MX, MX), 5);
        chk_list("ins_tie", pack4(5, 5, 5, MX));
        drive(1'b1, 1, 4, 8, 3, pack4(MX, MX, MX, MX), 10);
        chk_list("ins_empty", pack4(10, MX, MX, MX));
        chk_z("ins_empty_z", 32'd34);

        // Reset transparency: hold the last inputs through 3 reset cycles.
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk_list("rst_hold_list", pack4(10, MX, MX, MX));
            chk_z("rst_hold_z", 32'd34);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk_list("post_rst_list", pack4(10, MX, MX, MX));

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
